// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the instruction-cache RAM writer.
// The defaults describe a 64-set, 4-way cache with 256-bit lines filled by 64-bit beats.
package sargantana_icache_pkg;

   localparam int ICACHE_DEPTH_DEF = 64;
   localparam int ADDR_WIDHT_DEF   = 6;
   localparam int SET_WIDHT_DEF    = 256;
   localparam int BEAT_WIDTH_DEF   = 64;
   localparam int N_WAYS_DEF       = 4;

   localparam int NB = SET_WIDHT_DEF / BEAT_WIDTH_DEF;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE,
      FLUSH
   } ram_writer_state_t;

   typedef logic [SET_WIDHT_DEF-1:0] icache_line_t;

   // A single-beat line still needs a one-bit counter.
   function automatic int beat_cnt_width(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/sargantana_line_assembler.sv
// Collects refill beats into a full cache line, beat 0 in the least significant bits.
// o_last_beat is high while the next accepted beat completes the line.
module sargantana_line_assembler
   import sargantana_icache_pkg::*;
#(
   parameter int SET_WIDHT  = SET_WIDHT_DEF,
   parameter int BEAT_WIDTH = BEAT_WIDTH_DEF,
   parameter int N_BEATS    = NB
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  i_clear,
   input  logic                  i_beat_en,
   input  logic [BEAT_WIDTH-1:0] i_beat_data,
   output logic [SET_WIDHT-1:0]  o_line,
   output logic                  o_last_beat
);

   localparam int               LP_CW   = beat_cnt_width(N_BEATS);
   localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(N_BEATS - 1);

   logic [LP_CW-1:0] r_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_beat_en) begin
         r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_BEATS; gi++) begin : g_beat
         logic [BEAT_WIDTH-1:0] r_beat;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_beat <= '0;
            end else if (i_beat_en && (r_cnt == LP_CW'(gi))) begin
               r_beat <= i_beat_data;
            end
         end

         assign o_line[gi*BEAT_WIDTH +: BEAT_WIDTH] = r_beat;
      end
   endgenerate

   assign o_last_beat = (r_cnt == LP_LAST);

endmodule

// File: rtl/sargantana_icache_ram_writer.sv
// Drives the per-way icache set RAMs: refill line writes, whole-array flush sweeps,
// and core lookup reads, with writes always winning the shared port.
module sargantana_icache_ram_writer
   import sargantana_icache_pkg::*;
#(
   parameter int ICACHE_DEPTH = ICACHE_DEPTH_DEF,
   parameter int ADDR_WIDHT   = ADDR_WIDHT_DEF,
   parameter int SET_WIDHT    = SET_WIDHT_DEF,
   parameter int BEAT_WIDTH   = BEAT_WIDTH_DEF,
   parameter int N_WAYS       = N_WAYS_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  refill_start_i,
   input  logic [ADDR_WIDHT-1:0] refill_idx_i,
   input  logic [N_WAYS-1:0]     refill_way_i,
   input  logic                  beat_valid_i,
   input  logic [BEAT_WIDTH-1:0] beat_data_i,
   output logic                  beat_ready_o,
   input  logic                  flush_i,
   input  logic                  lookup_req_i,
   input  logic [ADDR_WIDHT-1:0] lookup_idx_i,
   output logic                  lookup_gnt_o,
   output logic [N_WAYS-1:0]     ram_req_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDHT-1:0] ram_addr_o,
   output logic [SET_WIDHT-1:0]  ram_data_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int                    LP_NB       = SET_WIDHT / BEAT_WIDTH;
   localparam logic [ADDR_WIDHT-1:0] LP_LAST_SET = ADDR_WIDHT'(ICACHE_DEPTH - 1);

   ram_writer_state_t      r_state;
   logic [ADDR_WIDHT-1:0]  r_flush_cnt;
   logic [ADDR_WIDHT-1:0]  r_idx;
   logic [N_WAYS-1:0]      r_way;
   logic                   r_flush_pending;
   logic                   r_done;

   logic                   w_beat_en;
   logic                   w_clear;
   logic                   w_last_beat;
   logic                   w_gnt;
   logic [SET_WIDHT-1:0]   w_line;

   assign w_beat_en = (r_state == COLLECT) && beat_valid_i;
   assign w_clear   = (r_state != COLLECT);

   sargantana_line_assembler #(
      .SET_WIDHT  (SET_WIDHT),
      .BEAT_WIDTH (BEAT_WIDTH),
      .N_BEATS    (LP_NB)
   ) u_line_assembler (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_clear     (w_clear),
      .i_beat_en   (w_beat_en),
      .i_beat_data (beat_data_i),
      .o_line      (w_line),
      .o_last_beat (w_last_beat)
   );

   // done_o is asserted on the transition into the completing cycle so it lines up with it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state         <= IDLE;
         r_flush_cnt     <= '0;
         r_idx           <= '0;
         r_way           <= '0;
         r_flush_pending <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (flush_i || r_flush_pending) begin
                  r_state         <= FLUSH;
                  r_flush_cnt     <= '0;
                  r_flush_pending <= 1'b0;
                  r_done          <= (ICACHE_DEPTH == 1);
               end else if (refill_start_i) begin
                  r_state <= COLLECT;
                  r_idx   <= refill_idx_i;
                  r_way   <= refill_way_i;
               end
            end
            COLLECT: begin
               if (flush_i) r_flush_pending <= 1'b1;
               if (w_beat_en && w_last_beat) begin
                  r_state <= WRITE;
                  r_done  <= 1'b1;
               end
            end
            WRITE: begin
               if (flush_i) r_flush_pending <= 1'b1;
               r_state <= IDLE;
            end
            FLUSH: begin
               if (flush_i) r_flush_pending <= 1'b1;
               if (r_flush_cnt == LP_LAST_SET) begin
                  r_state     <= IDLE;
                  r_flush_cnt <= '0;
               end else begin
                  r_flush_cnt <= r_flush_cnt + 1'b1;
                  r_done      <= ((r_flush_cnt + 1'b1) == LP_LAST_SET);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_gnt = lookup_req_i &&
                  ((r_state == COLLECT) ||
                   ((r_state == IDLE) && !flush_i && !r_flush_pending));

   always_comb begin
      ram_req_o  = '0;
      ram_we_o   = 1'b0;
      ram_addr_o = '0;
      ram_data_o = '0;
      case (r_state)
         WRITE: begin
            ram_req_o  = r_way;
            ram_we_o   = 1'b1;
            ram_addr_o = r_idx;
            ram_data_o = w_line;
         end
         FLUSH: begin
            ram_req_o  = '1;
            ram_we_o   = 1'b1;
            ram_addr_o = r_flush_cnt;
         end
         default: begin
            if (w_gnt) begin
               ram_req_o  = '1;
               ram_addr_o = lookup_idx_i;
            end
         end
      endcase
   end

   assign lookup_gnt_o = w_gnt;
   assign beat_ready_o = (r_state == COLLECT);
   assign busy_o       = (r_state != IDLE);
   assign done_o       = r_done;

endmodule

// File: tb/tb_sargantana_icache_ram_writer.sv
// Self-checking bench for the icache RAM writer: directed refill table, flush sweeps,
// reset abort, then randomized refills checked against a line-packing reference model.
module tb_sargantana_icache_ram_writer;
   import sargantana_icache_pkg::*;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         refill_start_i;
   logic [5:0]   refill_idx_i;
   logic [3:0]   refill_way_i;
   logic         beat_valid_i;
   logic [63:0]  beat_data_i;
   logic         beat_ready_o;
   logic         flush_i;
   logic         lookup_req_i;
   logic [5:0]   lookup_idx_i;
   logic         lookup_gnt_o;
   logic [3:0]   ram_req_o;
   logic         ram_we_o;
   logic [5:0]   ram_addr_o;
   logic [255:0] ram_data_o;
   logic         busy_o;
   logic         done_o;

   int checks = 0;
   int errors = 0;
   bit m_pending = 1'b0;

   sargantana_icache_ram_writer dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .refill_start_i (refill_start_i),
      .refill_idx_i   (refill_idx_i),
      .refill_way_i   (refill_way_i),
      .beat_valid_i   (beat_valid_i),
      .beat_data_i    (beat_data_i),
      .beat_ready_o   (beat_ready_o),
      .flush_i        (flush_i),
      .lookup_req_i   (lookup_req_i),
      .lookup_idx_i   (lookup_idx_i),
      .lookup_gnt_o   (lookup_gnt_o),
      .ram_req_o      (ram_req_o),
      .ram_we_o       (ram_we_o),
      .ram_addr_o     (ram_addr_o),
      .ram_data_o     (ram_data_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_i && refill_start_i && busy_o) begin
         errors++;
         $display("FAIL start_outside_idle: refill_start_i=1 while busy_o=1, required never");
      end
   end

   typedef struct {
      logic [5:0]   idx;
      logic [3:0]   way;
      logic [63:0]  a, b, c, d;
      logic [15:0]  pat;
      int           plen;
      bit           look;
      logic [5:0]   lidx;
      bit           flush_mid;
      logic [255:0] exp_data;
   } refill_vec_t;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Reference model: beat k lands at bits [k*64 +: 64] of the written line.
   function automatic icache_line_t model_line(input logic [63:0] b0, input logic [63:0] b1,
                                               input logic [63:0] b2, input logic [63:0] b3);
      icache_line_t l;
      logic [63:0]  bt [4];
      bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
      l = '0;
      for (int k = 0; k < NB; k++) l[k*64 +: 64] = bt[k];
      return l;
   endfunction

   task automatic idle_check(input string tag);
      logic exp_gnt;
      @(negedge clk);
      exp_gnt = lookup_req_i && !flush_i && !m_pending;
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_ready", beat_ready_o, 0);
      chk("idle_gnt", lookup_gnt_o, exp_gnt);
      chk("idle_req", ram_req_o, exp_gnt ? 4'hf : 4'h0);
      chk("idle_we", ram_we_o, 0);
      if (exp_gnt) chk("idle_addr", ram_addr_o, lookup_idx_i);
      @(posedge clk); #1;
      $display("idle %s: lookup=%0d gnt_expected=%0d", tag, lookup_req_i, exp_gnt);
   endtask

   task automatic do_refill(input refill_vec_t v, input string tag);
      logic [63:0] bt [4];
      int  k;
      int  cyc;
      bit  val;
      bt[0] = v.a; bt[1] = v.b; bt[2] = v.c; bt[3] = v.d;
      lookup_req_i   = v.look;
      lookup_idx_i   = v.lidx;
      refill_start_i = 1'b1;
      refill_idx_i   = v.idx;
      refill_way_i   = v.way;
      @(negedge clk);
      chk("start_busy", busy_o, 0);
      chk("start_gnt", lookup_gnt_o, v.look);
      @(posedge clk); #1;
      refill_start_i = 1'b0;
      refill_idx_i   = 6'($urandom);
      refill_way_i   = 4'($urandom);
      k = 0;
      cyc = 0;
      while (k < 4 && cyc < 40) begin
         val = (cyc < v.plen) ? v.pat[cyc[3:0]] : 1'b1;
         beat_valid_i = val;
         beat_data_i  = val ? bt[k] : {$urandom, $urandom};
         flush_i      = v.flush_mid && (cyc == 1);
         if (flush_i) m_pending = 1'b1;
         @(negedge clk);
         chk("col_ready", beat_ready_o, 1);
         chk("col_busy", busy_o, 1);
         chk("col_we", ram_we_o, 0);
         chk("col_done", done_o, 0);
         chk("col_gnt", lookup_gnt_o, v.look);
         if (v.look) begin
            chk("col_addr", ram_addr_o, v.lidx);
            chk("col_req", ram_req_o, 4'hf);
         end
         @(posedge clk); #1;
         if (val) k++;
         cyc++;
      end
      beat_valid_i = 1'b0;
      flush_i      = 1'b0;
      if (k < 4) begin
         checks++;
         errors++;
         $display("FAIL refill_timeout: accepted %0d beats, required 4", k);
      end
      @(negedge clk);
      chk("wr_req", ram_req_o, v.way);
      chk("wr_we", ram_we_o, 1);
      chk("wr_addr", ram_addr_o, v.idx);
      chk("wr_data", ram_data_o, v.exp_data);
      chk("wr_done", done_o, 1);
      chk("wr_gnt", lookup_gnt_o, 0);
      chk("wr_ready", beat_ready_o, 0);
      @(posedge clk); #1;
      $display("refill %s: idx=%0d way=%b cycles=%0d look=%0d flush_mid=%0d", tag, v.idx, v.way,
               cyc, v.look, v.flush_mid);
   endtask

   task automatic flush_sweep(input bit pulse, input string tag);
      lookup_req_i = 1'b1;
      lookup_idx_i = 6'($urandom);
      flush_i      = pulse;
      @(negedge clk);
      chk("fl_pre_busy", busy_o, 0);
      chk("fl_pre_gnt", lookup_gnt_o, 0);
      chk("fl_pre_we", ram_we_o, 0);
      chk("fl_pre_req", ram_req_o, 0);
      chk("fl_pre_done", done_o, 0);
      @(posedge clk); #1;
      flush_i   = 1'b0;
      m_pending = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         chk("fl_we", ram_we_o, 1);
         chk("fl_req", ram_req_o, 4'hf);
         chk("fl_addr", ram_addr_o, i);
         chk("fl_data", ram_data_o, 0);
         chk("fl_gnt", lookup_gnt_o, 0);
         chk("fl_busy", busy_o, 1);
         chk("fl_done", done_o, (i == 63));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("fl_post_busy", busy_o, 0);
      chk("fl_post_done", done_o, 0);
      chk("fl_post_gnt", lookup_gnt_o, 1);
      chk("fl_post_addr", ram_addr_o, lookup_idx_i);
      @(posedge clk); #1;
      lookup_req_i = 1'b0;
      $display("flush %s: 64-cycle sweep checked", tag);
   endtask

   refill_vec_t tbl [4];
   refill_vec_t rv;

   initial begin
      logic [63:0] A, B, C, D, E, F, G, H;
      A = 64'hAAAA_0000_1111_0001; B = 64'hBBBB_0000_2222_0002;
      C = 64'hCCCC_0000_3333_0003; D = 64'hDDDD_0000_4444_0004;
      E = 64'hEEEE_5555_0000_0005; F = 64'hFFFF_6666_0000_0006;
      G = 64'h1234_7777_0000_0007; H = 64'h5678_8888_0000_0008;

      tbl[0] = '{6'd5,  4'b0010, A, B, C, D, 16'h0000, 0, 1'b0, 6'd0,  1'b0, {D, C, B, A}};
      tbl[1] = '{6'd5,  4'b0010, A, B, C, D, 16'h0059, 7, 1'b0, 6'd0,  1'b0, {D, C, B, A}};
      tbl[2] = '{6'd12, 4'b1000, E, F, G, H, 16'h0000, 0, 1'b1, 6'd9,  1'b0, {H, G, F, E}};
      tbl[3] = '{6'd63, 4'b0001, H, G, F, E, 16'h0005, 4, 1'b1, 6'd0,  1'b0, {E, F, G, H}};

      rst_i = 1'b1; refill_start_i = 1'b0; refill_idx_i = '0; refill_way_i = '0;
      beat_valid_i = 1'b0; beat_data_i = '0; flush_i = 1'b0;
      lookup_req_i = 1'b0; lookup_idx_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_ready", beat_ready_o, 0);
      chk("rst_req", ram_req_o, 0);
      chk("rst_we", ram_we_o, 0);
      chk("rst_gnt", lookup_gnt_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0;

      for (int i = 0; i < 4; i++) begin
         do_refill(tbl[i], $sformatf("tbl%0d", i));
         idle_check($sformatf("after_tbl%0d", i));
      end

      flush_sweep(1'b1, "pulse_in_idle");

      rv = tbl[0];
      rv.flush_mid = 1'b1;
      rv.look = 1'b1;
      rv.lidx = 6'd33;
      do_refill(rv, "flush_mid_collect");
      flush_sweep(1'b0, "pending");

      // Reset after two of four beats abandons the refill.
      refill_start_i = 1'b1; refill_idx_i = 6'd20; refill_way_i = 4'b0100;
      @(posedge clk); #1;
      refill_start_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         beat_valid_i = 1'b1;
         beat_data_i  = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      beat_valid_i = 1'b0;
      rst_i = 1'b1;
      #1;
      chk("abort_busy", busy_o, 0);
      chk("abort_ready", beat_ready_o, 0);
      chk("abort_we", ram_we_o, 0);
      chk("abort_done", done_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      idle_check("after_abort");
      rv = '{6'd20, 4'b0100, E, F, G, H, 16'h0000, 0, 1'b0, 6'd0, 1'b0, {H, G, F, E}};
      do_refill(rv, "after_abort");
      idle_check("after_abort_refill");

      for (int it = 0; it < 12; it++) begin
         rv.idx  = 6'($urandom);
         rv.way  = 4'(1 << $urandom_range(0, 3));
         rv.a    = {$urandom, $urandom};
         rv.b    = {$urandom, $urandom};
         rv.c    = {$urandom, $urandom};
         rv.d    = {$urandom, $urandom};
         rv.pat  = 16'($urandom);
         rv.plen = $urandom_range(0, 12);
         rv.look = 1'($urandom);
         rv.lidx = 6'($urandom);
         rv.flush_mid = ($urandom_range(0, 3) == 0);
         rv.exp_data  = model_line(rv.a, rv.b, rv.c, rv.d);
         do_refill(rv, $sformatf("rand%0d", it));
         if (rv.flush_mid) begin
            flush_sweep(1'b0, $sformatf("rand%0d", it));
         end else begin
            lookup_req_i = 1'($urandom);
            lookup_idx_i = 6'($urandom);
            idle_check($sformatf("rand%0d", it));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sargantana_icache_ram_writer.md
Name: sargantana_icache_ram_writer

Overview:
Initiator-side controller for the instruction-cache set RAMs, one RAM instance per way (req/we/addr/data single-port, synchronous read).
- Assembles refill lines from narrow memory-response beats and issues one full-line write to the selected way.
- Runs a whole-array invalidate (flush) sweep.
- Arbitrates the shared RAM port between its own writes and core lookup reads.

Parameters:
ICACHE_DEPTH, 64, number of sets (RAM entries per way)
ADDR_WIDHT, 6, set-index width, equals log2(ICACHE_DEPTH)
SET_WIDHT, 256, line width in bits
BEAT_WIDTH, 64, refill beat width; SET_WIDHT must be an integer multiple of it
N_WAYS, 4, number of ways (RAM instances)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
refill_start_i  in  1  begin refill; sampled in IDLE only
refill_idx_i  in  ADDR_WIDHT  set index of the refill
refill_way_i  in  N_WAYS  one-hot victim way
beat_valid_i  in  1  refill beat valid
beat_data_i  in  BEAT_WIDTH  refill beat payload
beat_ready_o  out  1  beat accepted when valid&&ready
flush_i  in  1  request whole-array invalidate
lookup_req_i  in  1  core read request
lookup_idx_i  in  ADDR_WIDHT  core read index
lookup_gnt_o  out  1  lookup issued to the RAMs this cycle
ram_req_o  out  N_WAYS  per-way RAM request
ram_we_o  out  1  RAM write enable (shared by all ways)
ram_addr_o  out  ADDR_WIDHT  RAM address
ram_data_o  out  SET_WIDHT  RAM write data
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse when a refill write or flush completes

Behaviour:
- Beats per line: NB = SET_WIDHT/BEAT_WIDTH. Beat counter width is clog2(NB), minimum 1.
- FSM states: IDLE, COLLECT, WRITE, FLUSH.
- Reset (asynchronous, rst_i=1):
  - state=IDLE; beat counter, flush counter, flush_pending, line buffer, latched idx/way and done_o all cleared to 0.
  - No write is issued while rst_i=1.
  - Reset mid-COLLECT or mid-FLUSH abandons the operation with no write and no done pulse.
- IDLE:
  - flush_i || flush_pending -> FLUSH; flush counter=0; clear flush_pending.
  - Else refill_start_i -> COLLECT; latch refill_idx_i and refill_way_i; beat counter=0.
  - Flush beats refill when both are asserted in the same cycle; the refill request is dropped, and the caller must retry when busy_o=0.
- COLLECT:
  - beat_ready_o=1.
  - On beat_valid_i: write beat k into line[k*BEAT_WIDTH +: BEAT_WIDTH] (beat 0 = LSBs); increment counter.
  - Cycles with beat_valid_i=0 hold the counter and the buffer.
  - Acceptance of beat NB-1 -> WRITE on the next cycle.
- WRITE (exactly 1 cycle):
  - ram_req_o=latched way, ram_we_o=1, ram_addr_o=latched idx, ram_data_o=line.
  - done_o=1; next state IDLE.
- FLUSH:
  - ram_req_o all ones, ram_we_o=1, ram_addr_o=flush counter, ram_data_o=0.
  - The counter increments every cycle.
  - At counter ICACHE_DEPTH-1: done_o=1, next IDLE; the counter wraps to 0.
  - The sweep takes exactly ICACHE_DEPTH cycles.
- flush_i in COLLECT/WRITE/FLUSH sets flush_pending; it is served on return to IDLE (IDLE->FLUSH in the next cycle).
- refill_start_i outside IDLE is ignored; the bench asserts that it never occurs.
- Lookup arbitration (combinational):
  - lookup_gnt_o = lookup_req_i && (state==COLLECT || (state==IDLE && !flush_i && !flush_pending)).
  - When granted: ram_req_o all ones, ram_we_o=0, ram_addr_o=lookup_idx_i, ram_data_o=0.
  - Read data appears at the RAM outputs one cycle later; it does not pass through this block.
  - Writes always take priority, so a lookup during WRITE or FLUSH sees gnt=0 and must be held by the requester.
- With no lookup and no write, all ram_* outputs are 0.
- beat_ready_o=0 outside COLLECT.
- done_o is registered; all other outputs are combinational from state and inputs.

Decomposition:
- Package sargantana_icache_pkg holds:
  - state enum ram_writer_state_t {IDLE, COLLECT, WRITE, FLUSH};
  - constant NB (beats per line);
  - a line typedef.
- One natural sub-module: sargantana_line_assembler (beat counter plus line buffer, with last-beat flag).
- The FSM and arbitration stay in the top module.

Test Plan:
1. Refill idx=5, way=4'b0010, beats A,B,C,D back-to-back -> one cycle after beat D: ram_req_o=0010, we=1, addr=5, data={D,C,B,A}, done_o=1; then IDLE.
2. Same refill with valid gaps (pattern 1,0,0,1,1,0,1) -> exactly 4 beats accepted; write data identical to scenario 1; no early write.
3. Lookup idx=9 held during COLLECT, then through WRITE -> gnt=1, addr=9, we=0 in COLLECT; gnt=0 in the WRITE cycle; gnt=1 again in IDLE.
4. flush_i pulse in IDLE with lookup_req_i=1 -> gnt=0; 64 consecutive cycles of we=1, req=1111, addr 0..63, data=0; done_o at addr 63; busy_o low the cycle after.
5. flush_i pulse mid-COLLECT -> refill completes normally; one IDLE cycle; then a full 64-cycle flush; two done pulses in total.
6. rst_i asserted after 2 of 4 beats -> immediate IDLE, beat_ready_o=0, no write, no done_o; a subsequent refill needs a full 4 new beats.
